// File: rtl/sysctl_icapseq_pkg.sv
// Shared types and constants for the sysctl ICAP IPROG sequencer.
package sysctl_icapseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [3:0] NWORDS      = 4'd10;
  localparam logic [3:0] RELEASE_IDX = 4'd10;

  localparam logic [15:0] SYNC_DUMMY = 16'hFFFF;
  localparam logic [15:0] SYNC0      = 16'hAA99;
  localparam logic [15:0] SYNC1      = 16'h5566;
  localparam logic [15:0] WR_GEN1    = 16'h3261;
  localparam logic [15:0] WR_GEN2    = 16'h3281;
  localparam logic [7:0]  IPROG_OPC  = 8'h03;
  localparam logic [15:0] WR_CMD     = 16'h30A1;
  localparam logic [15:0] CMD_IPROG  = 16'h000E;
  localparam logic [15:0] NOOP       = 16'h2000;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_BOOTADDR = 2'd1;
  localparam logic [1:0] REG_WORDIDX  = 2'd2;

endpackage

// File: rtl/sysctl_icapseq_rom.sv
// Combinational IPROG word table: index + boot address -> {ce, write, d}.
// Any index past the last command word yields the release word (port deselected).
module sysctl_icapseq_rom
  import sysctl_icapseq_pkg::*;
(
  input  logic [3:0]  i_idx,
  input  logic [23:0] i_bootaddr,
  output logic        o_ce,
  output logic        o_write,
  output logic [15:0] o_d
);

  always_comb begin
    o_ce    = 1'b0;
    o_write = 1'b0;
    o_d     = 16'h0000;
    case (i_idx)
      4'd0: o_d = SYNC_DUMMY;
      4'd1: o_d = SYNC0;
      4'd2: o_d = SYNC1;
      4'd3: o_d = WR_GEN1;
      4'd4: o_d = i_bootaddr[15:0];
      4'd5: o_d = WR_GEN2;
      4'd6: o_d = {IPROG_OPC, i_bootaddr[23:16]};
      4'd7: o_d = WR_CMD;
      4'd8: o_d = CMD_IPROG;
      4'd9: o_d = NOOP;
      default: begin
        o_ce    = 1'b1;
        o_write = 1'b1;
        o_d     = 16'h0000;
      end
    endcase
  end

endmodule

// File: rtl/sysctl_icapseq.sv
// ICAP IPROG sequencer with CSR control; streams 10 command words plus a release word.
// Optional ready watchdog under SYSCTL_ICAPSEQ_WATCHDOG_EN.
module sysctl_icapseq
  import sysctl_icapseq_pkg::*;
#(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter logic [15:0] timeout  = 16'd1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        icap_ready,
  output logic        icap_we,
  output logic [15:0] icap_d,
  output logic        icap_ce,
  output logic        icap_write,
  output logic        irq
);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_aborted, w_aborted_nxt;
  logic        r_irq, w_irq_nxt;
  logic        r_we, w_we_nxt;
  logic [15:0] r_d, w_d_nxt;
  logic        r_ce, w_ce_nxt;
  logic        r_write, w_write_nxt;
  logic [23:0] r_bootaddr;
  logic [31:0] r_csr_do;

  logic        w_sel, w_ctrl_wr, w_start, w_abort, w_aborted_any, w_wd_expire;
  logic        w_rom_ce, w_rom_write;
  logic [15:0] w_rom_d;
  logic        w_unused_bits;

  assign w_sel     = (csr_a[13:10] == csr_addr);
  assign w_ctrl_wr = w_sel & csr_we & (csr_a[1:0] == REG_CTRL);
  // Abort takes priority over a simultaneous start.
  assign w_start   = w_ctrl_wr & csr_di[0] & ~csr_di[1] & (r_state == ST_IDLE);
  assign w_abort   = w_ctrl_wr & csr_di[1] & r_busy;
  assign w_aborted_any = r_aborted | w_abort;
  assign w_unused_bits = ^{csr_a[9:2], csr_di[31:24]};

  sysctl_icapseq_rom u_rom (
    .i_idx      (r_idx),
    .i_bootaddr (r_bootaddr),
    .o_ce       (w_rom_ce),
    .o_write    (w_rom_write),
    .o_d        (w_rom_d)
  );

`ifdef SYSCTL_ICAPSEQ_WATCHDOG_EN
  logic [15:0] r_wd;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wd <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wd <= '0;
    end else if ((r_state == ST_ISSUE || r_state == ST_WAIT) && !icap_ready) begin
      r_wd <= r_wd + 16'd1;
    end
  end

  assign w_wd_expire = (r_state == ST_ISSUE || r_state == ST_WAIT) && !icap_ready &&
                       (r_wd == timeout - 16'd1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout;
  assign w_wd_expire      = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      r_irq     <= 1'b0;
      r_we      <= 1'b0;
      r_d       <= '0;
      r_ce      <= 1'b1;
      r_write   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_aborted <= w_aborted_nxt;
      r_irq     <= w_irq_nxt;
      r_we      <= w_we_nxt;
      r_d       <= w_d_nxt;
      r_ce      <= w_ce_nxt;
      r_write   <= w_write_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (w_abort)          w_state_nxt = ST_ISSUE;
        else if (icap_ready)  w_state_nxt = ST_HOLD;
        else if (w_wd_expire) w_state_nxt = ST_ERROR;
      end
      // ready is not trusted the cycle after we, so HOLD never samples it.
      ST_HOLD:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (icap_ready) begin
          if (r_idx == RELEASE_IDX) w_state_nxt = w_aborted_any ? ST_ERROR : ST_DONE;
          else                      w_state_nxt = ST_ISSUE;
        end else if (w_abort) begin
          w_state_nxt = (r_idx == RELEASE_IDX) ? ST_WAIT : ST_ISSUE;
        end else if (w_wd_expire) begin
          w_state_nxt = ST_ERROR;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idx_nxt     = r_idx;
    w_aborted_nxt = w_aborted_any;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_err_nxt     = r_err;
    w_irq_nxt     = 1'b0;
    w_we_nxt      = 1'b0;
    w_d_nxt       = r_d;
    w_ce_nxt      = r_ce;
    w_write_nxt   = r_write;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_idx_nxt     = '0;
          w_aborted_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_err_nxt     = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (w_abort) begin
          w_idx_nxt = RELEASE_IDX;
        end else if (icap_ready) begin
          w_we_nxt    = 1'b1;
          w_d_nxt     = w_rom_d;
          w_ce_nxt    = w_rom_ce;
          w_write_nxt = w_rom_write;
        end
      end
      ST_WAIT: begin
        if (icap_ready) begin
          if (r_idx != RELEASE_IDX)
            w_idx_nxt = (w_aborted_any || r_idx >= NWORDS) ? RELEASE_IDX : r_idx + 4'd1;
        end else if (w_abort) begin
          w_idx_nxt = RELEASE_IDX;
        end
      end
      default: ;
    endcase
    if (w_state_nxt == ST_DONE) begin
      w_done_nxt = 1'b1;
      w_busy_nxt = 1'b0;
      w_irq_nxt  = 1'b1;
    end
    if (w_state_nxt == ST_ERROR) begin
      w_err_nxt  = 1'b1;
      w_busy_nxt = 1'b0;
      w_irq_nxt  = 1'b1;
    end
    if (w_state_nxt == ST_IDLE) begin
      w_d_nxt     = 16'h0000;
      w_ce_nxt    = 1'b1;
      w_write_nxt = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_bootaddr <= '0;
      r_csr_do   <= '0;
    end else begin
      if (w_sel && csr_we && csr_a[1:0] == REG_BOOTADDR && !r_busy)
        r_bootaddr <= csr_di[23:0];
      if (!w_sel) begin
        r_csr_do <= '0;
      end else begin
        case (csr_a[1:0])
          REG_CTRL:     r_csr_do <= {29'b0, r_err, r_done, r_busy};
          REG_BOOTADDR: r_csr_do <= {8'b0, r_bootaddr};
          REG_WORDIDX:  r_csr_do <= {28'b0, r_idx};
          default:      r_csr_do <= '0;
        endcase
      end
    end
  end

  assign csr_do     = r_csr_do;
  assign icap_we    = r_we;
  assign icap_d     = r_d;
  assign icap_ce    = r_ce;
  assign icap_write = r_write;
  assign irq        = r_irq;

endmodule

// File: tb/tb_sysctl_icapseq.sv
// Directed bench for sysctl_icapseq with a simple ICAP ready model and word logger.
module tb_sysctl_icapseq;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        icap_ready;
  logic        icap_we;
  logic [15:0] icap_d;
  logic        icap_ce;
  logic        icap_write;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;
  int irq_cnt  = 0;
  int busy_cnt = 0;
  logic stuck  = 1'b0;
  logic [17:0] wlog [$];
  logic [17:0] exp_w [0:10];

  localparam logic [13:0] A_CTRL = 14'h0000;
  localparam logic [13:0] A_BOOT = 14'h0001;
  localparam logic [13:0] A_IDX  = 14'h0002;

  sysctl_icapseq #(.csr_addr(4'h0), .timeout(16'd16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .csr_a      (csr_a),
    .csr_we     (csr_we),
    .csr_di     (csr_di),
    .csr_do     (csr_do),
    .icap_ready (icap_ready),
    .icap_we    (icap_we),
    .icap_d     (icap_d),
    .icap_ce    (icap_ce),
    .icap_write (icap_write),
    .irq        (irq)
  );

  always #5 sys_clk = ~sys_clk;

  // ICAP model: ready drops for 3 cycles after each word; 'stuck' holds it low.
  initial begin
    icap_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      if (icap_we) begin
        wlog.push_back({icap_ce, icap_write, icap_d});
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
      icap_ready = (busy_cnt == 0) && !stuck;
      if (irq) irq_cnt = irq_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    @(posedge sys_clk); #1;
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(posedge sys_clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    @(posedge sys_clk); #1;
    csr_a = a; csr_we = 1'b0;
    @(posedge sys_clk); #1;
    d = csr_do;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (wlog.size() < n && k < budget) begin
      @(posedge sys_clk); #2;
      k++;
    end
    check_eq("words_reached", wlog.size(), n);
  endtask

  task automatic wait_irq(input int n, input int budget);
    int k = 0;
    while (irq_cnt < n && k < budget) begin
      @(posedge sys_clk); #2;
      k++;
    end
    check_eq("irq_reached", irq_cnt, n);
  endtask

  initial begin
    logic [31:0] rd, rd2;
    int k;
    exp_w = '{18'h0FFFF, 18'h0AA99, 18'h05566, 18'h03261, 18'h03456, 18'h03281,
              18'h00312, 18'h030A1, 18'h0000E, 18'h02000, 18'h30000};
    sys_rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst_we", icap_we, 0);
    check_eq("rst_ce_wr_d", {icap_ce, icap_write, icap_d}, 18'h30000);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_csr_do", csr_do, 0);
    sys_rst = 1'b0;
    csr_read(A_CTRL, rd); check_eq("rst_ctrl", rd, 0);
    csr_read(A_BOOT, rd); check_eq("rst_boot", rd, 0);

    // Nominal IPROG sequence
    csr_write(A_BOOT, 32'h00123456);
    csr_read(A_BOOT, rd); check_eq("boot_rb", rd, 32'h123456);
    wlog.delete();
    csr_write(A_CTRL, 32'h1);
    wait_irq(1, 500);
    repeat (5) @(posedge sys_clk);
    #2;
    check_eq("nom_irq_once", irq_cnt, 1);
    check_eq("nom_count", wlog.size(), 11);
    for (int i = 0; i < 11; i++) check_eq($sformatf("nom_w%0d", i), wlog[i], exp_w[i]);
    csr_read(A_CTRL, rd); check_eq("nom_ctrl", rd, 2);
    csr_read(A_IDX, rd); check_eq("nom_idx_sat", rd, 10);
    csr_read(14'h0400, rd); check_eq("offpage_rd", rd, 0);
    check_eq("idle_ce_wr", {icap_ce, icap_write}, 2'b11);

    // Ready stalled at word 4
    wlog.delete();
    csr_write(A_CTRL, 32'h1);
    wait_words(5, 200);
    stuck = 1'b1;
    repeat (50) @(posedge sys_clk);
    #2;
    check_eq("stall_nowe", wlog.size(), 5);
    check_eq("stall_d", icap_d, 16'h3456);
    csr_read(A_CTRL, rd); check_eq("stall_busy", rd, 1);
    stuck = 1'b0;
    wait_irq(2, 500);
    check_eq("stall_count", wlog.size(), 11);
    csr_read(A_CTRL, rd); check_eq("stall_ctrl", rd, 2);

    // Abort mid-stream
    wlog.delete();
    csr_write(A_CTRL, 32'h1);
    wait_words(5, 200);
    csr_write(A_CTRL, 32'h2);
    wait_irq(3, 500);
    repeat (5) @(posedge sys_clk);
    #2;
    check_eq("abort_count", wlog.size(), 6);
    check_eq("abort_rel", wlog[5], 18'h30000);
    check_eq("abort_irq_once", irq_cnt, 3);
    csr_read(A_CTRL, rd); check_eq("abort_ctrl", rd, 4);
    csr_write(A_CTRL, 32'h3);
    repeat (10) @(posedge sys_clk);
    #2;
    check_eq("start_abort_ign", wlog.size(), 6);
    csr_read(A_CTRL, rd); check_eq("start_abort_ctrl", rd, 4);

    // Writes while busy are ignored
    wlog.delete();
    csr_write(A_CTRL, 32'h1);
    wait_words(3, 200);
    csr_read(A_IDX, rd);
    csr_write(A_CTRL, 32'h1);
    csr_write(A_BOOT, 32'h00ABCDEF);
    csr_read(A_BOOT, rd2); check_eq("busy_boot_rb", rd2, 32'h123456);
    csr_read(A_IDX, rd2); check_eq("idx_monotonic", rd2 >= rd, 1);
    wait_irq(4, 500);
    check_eq("busy_count", wlog.size(), 11);
    check_eq("busy_w4", wlog[4], exp_w[4]);
    check_eq("busy_w6", wlog[6], exp_w[6]);
    csr_read(A_CTRL, rd); check_eq("busy_ctrl", rd, 2);

    // Port stuck after word 2
    wlog.delete();
    csr_write(A_CTRL, 32'h1);
    wait_words(3, 200);
    stuck = 1'b1;
`ifdef SYSCTL_ICAPSEQ_WATCHDOG_EN
    k = 0;
    while (irq_cnt == 4 && k < 100) begin
      @(posedge sys_clk); #2;
      k++;
    end
    check_eq("wd_latency", k - 1, 16);
    csr_read(A_CTRL, rd); check_eq("wd_ctrl", rd, 4);
    check_eq("wd_no_release", wlog.size(), 3);
    check_eq("wd_idle_ce_wr", {icap_ce, icap_write}, 2'b11);
    stuck = 1'b0;
    k = 5;
`else
    repeat (1000) @(posedge sys_clk);
    #2;
    check_eq("nowd_irq", irq_cnt, 4);
    csr_read(A_CTRL, rd); check_eq("nowd_busy", rd, 1);
    stuck = 1'b0;
    wait_irq(5, 500);
    csr_read(A_CTRL, rd); check_eq("nowd_ctrl", rd, 2);
    k = 5;
`endif

    // Asynchronous reset in the middle of word 7
    wlog.delete();
    repeat (5) @(posedge sys_clk);
    csr_write(A_CTRL, 32'h1);
    csr_a = A_CTRL;
    wait_words(8, 300);
    #1 sys_rst = 1'b1;
    #1;
    check_eq("arst_we", icap_we, 0);
    check_eq("arst_ce_wr_d", {icap_ce, icap_write, icap_d}, 18'h30000);
    check_eq("arst_csr_do", csr_do, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    csr_read(A_CTRL, rd); check_eq("arst_ctrl", rd, 0);
    csr_read(A_IDX, rd); check_eq("arst_idx", rd, 0);
    repeat (20) @(posedge sys_clk);
    #2;
    check_eq("arst_no_irq", irq_cnt, k);
    check_eq("arst_no_we", wlog.size(), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sysctl_icapseq.md
Name: sysctl_icapseq

Overview:
- Hardware sequencer that drives the sysctl ICAP port (ready/we/d/ce/write handshake) through a complete multiboot reconfiguration (IPROG) command stream, so software does not write each ICAP word by hand.
- Software programs a boot address, sets start, and the block streams the words.
- Lives in the sysctl CSR space beside the GPIO/timer logic; raises a one-cycle irq on completion or error.

Parameters:
- csr_addr, 4'h0, CSR page matched against csr_a[13:10].
- timeout, 16'd1024, maximum cycles waiting for icap_ready before error (watchdog build only).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- csr_a  in  14  CSR address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered, 0 when not selected
- icap_ready  in  1  ICAP port idle and able to accept a word
- icap_we  out  1  one-cycle word strobe to ICAP port
- icap_d  out  16  ICAP word
- icap_ce  out  1  ICAP CE_B value (0 = active)
- icap_write  out  1  ICAP WRITE_B value (0 = write)
- irq  out  1  one-cycle pulse on DONE or ERROR entry

Behaviour:
- Reset: all state cleared asynchronously. csr_do=0, icap_we=0, icap_d=0, icap_ce=1, icap_write=1, irq=0, bootaddr=0, state IDLE, busy=0, done=0, err=0.
- CSR map (csr_a[1:0] while selected):
  - 00 CTRL: write bit0=start (ignored unless IDLE), bit1=abort. Read {29'b0, err, done, busy}.
  - 01 BOOTADDR: 24-bit read/write. Writes are ignored while busy.
  - 10 WORDIDX: read-only 4-bit index of the next word.
- Read latency is 1 cycle.
- Word stream, index 0..9, all sent with ce=0 and write=0:
  - FFFF, AA99, 5566, 3261, bootaddr[15:0], 3281, {8'h03, bootaddr[23:16]}, 30A1, 000E, 2000.
  - Index 10 is the release word: d=0000, ce=1, write=1.
- FSM states: IDLE, ISSUE, HOLD, WAIT, DONE, ERROR.
  - IDLE --start--> ISSUE. Start clears done/err, sets busy, index=0.
  - ISSUE: if icap_ready=1, assert icap_we for exactly 1 cycle with d/ce/write for the current index, then go to HOLD. If icap_ready=0, stay in ISSUE.
  - HOLD: 1 cycle with ready ignored, because ready falls the cycle after we. Then go to WAIT.
  - WAIT: on icap_ready=1, index++. If index was 10, go to DONE; otherwise go to ISSUE.
  - DONE: done=1, busy=0, irq pulse, then IDLE on the next cycle. The done flag persists until the next start.
  - ERROR: err=1, busy=0, irq pulse, then IDLE.
- icap_d/ce/write are held stable from the we cycle until the next ISSUE. They return to ce=1 and write=1 in IDLE.
- Abort while busy:
  - Abort in ISSUE/WAIT: jump directly to the release word, i.e. index=10, issued at the next ready.
  - Abort in HOLD: the release word follows the in-flight word.
  - Completion after abort sets err=1, not done.
  - Abort while IDLE has no effect.
- Start and abort written in the same cycle: abort wins and start is ignored.
- Start while busy is ignored.
- The index counter saturates at 10 and never wraps.

Optional Feature:
- SYSCTL_ICAPSEQ_WATCHDOG_EN defined:
  - A 16-bit counter runs in ISSUE and WAIT and resets on each transition.
  - When it reaches timeout with ready still 0, the FSM enters ERROR.
  - No release word is sent in this case, since the port is stuck.
- Undefined:
  - The FSM waits indefinitely.
  - err is set only by abort.
  - The counter is not synthesised.

Decomposition:
- Package sysctl_icapseq_pkg holds:
  - the state enum;
  - word count constants (NWORDS=10, RELEASE_IDX=10);
  - the ICAP constants SYNC_DUMMY, SYNC0, SYNC1, WR_GEN1, WR_GEN2, IPROG_OPC, WR_CMD, CMD_IPROG, NOOP;
  - the CSR register offsets.
- One sub-module, sysctl_icapseq_rom: a purely combinational index + bootaddr → {ce, write, d} lookup.

Test Plan:
- Nominal, ready toggles low 3 cycles after each we, bootaddr=0x123456, start → exactly 11 we pulses with d = FFFF, AA99, 5566, 3261, 3456, 3281, 0312, 30A1, 000E, 2000, 0000. The last word has ce=1 and write=1. Then one irq pulse; CTRL reads 0x2.
- Ready held 0 for 50 cycles at word 4 → no extra we pulse; d stays 3456; the sequence resumes after ready rises; done=1.
- Abort written at word 5 → the next we carries the release word (ce=1, write=1); total 6 pulses; CTRL reads 0x4; one irq.
- Writes while busy: start → no restart, WORDIDX stays monotonic. BOOTADDR write of 0xABCDEF → readback unchanged, stream unchanged.
- Watchdog build, timeout=16: ready stuck at 0 after word 2 → ERROR reached 16 cycles after entering WAIT; CTRL reads 0x4; no release word sent. Non-watchdog build: still busy after 1000 cycles.
- Assert sys_rst asynchronously mid-sequence (word 7) → outputs immediately at reset values (we=0, ce=1, write=1); state IDLE; CTRL reads 0; no irq.
